hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised pipeline hazard unit for the five-stage MIPS core. It keeps its own record of the destination register and result-ready time of every instruction in E, M and W, and generates the D-stage stall and all forwarding selects from that record. It also owns the multiply/divide busy countdown, so the core no longer needs an external Busy input. Decode supplies per-instruction register-use and register-write information; the unit needs no instruction words.

## Interface
- AW, 5, register address width
- TW, 2, width of Tuse/Tnew fields
- MUL_CYC, 5, busy cycles after a multiply start
- DIV_CYC, 10, busy cycles after a divide start
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- d_rs, d_rt  in  AW  D-stage source registers
- d_use_rs, d_use_rt  in  1  source actually read
- d_tuse_rs, d_tuse_rt  in  TW  cycles after entering D until the source value is needed (0 means needed in D)
- d_wa  in  AW  D-stage destination register
- d_we  in  1  instruction writes d_wa
- d_tnew  in  TW  cycles after entering E until the result exists (0 means the result is produced in E)
- d_md_op  in  2  md start class: 00 none, 01 mul, 10 div
- d_md_use  in  1  instruction starts md or touches hi/lo
- stall  out  1  freeze PC and FD; E receives a bubble
- fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt  out  2 each  forward select: 0 none, 1 from E, 2 from M, 3 from W
- e_md_op  out  2  md start to the E-stage XALU
- md_busy  out  1  md unit busy

## Operation
- Slots: E holds {wa, we, tnew, rs, rt, use_rs, use_rt, md_op}. M holds {wa, we, tnew, rt, use_rt}. W holds {wa, we}.
- A write counts only if we=1 and wa≠0.
- Each clock edge:
  - M ← E, with tnew = max(tnew_E−1, 0).
  - W ← M.
  - E ← D fields, or all-zero (a bubble) if stall=1.
- Producer match: the stage holds a counted write to the same register as a used source.
- D source (rs or rt, same rule for each):
  - The nearest matching producer is found, searching E, then M, then W.
  - Forward select is 1, 2 or 3 for that stage only if its tnew is 0 (W is always 0).
  - If the nearest producer's tnew is nonzero, the select is 0; an older producer must never be used.
- E sources: same rule, searching M then W.
- M rt: searching W only.
- Data stall: for a used D source, stall if (match E and tnew_E > tuse) or (match M and tnew_M > tuse).
- md stall: d_md_use and (e_md_op≠00 or md_busy).
- stall is the OR of the data stall and the md stall.
- e_md_op equals the E-slot md_op.
- Busy counter, width $clog2(DIV_CYC+1):
  - On an edge with e_md_op=01 it loads MUL_CYC; with 10 it loads DIV_CYC.
  - Otherwise it decrements while nonzero.
  - md_busy = (count≠0).
  - A load takes priority over a decrement.
- Reset (asynchronous) clears all slots and the counter. All outputs are 0 during and after reset until new D inputs arrive.

## Timing
- stall and all fwd_* are combinational from the slots and the D inputs, with no added latency.
- Slot updates happen on the rising clk edge.
- Bubble rule: the cycle after stall=1, the E slot is zero, so none of its outputs match.
- Stall with a tnew=2 load in E and tuse=0 in D: 2 cycles of stall (tnew in M is 1 > 0). On the third cycle D forwards from W.
- mult in E at cycle t: e_md_op=01 at t; md_busy=1 for t+1 … t+MUL_CYC. A dependent mfhi stalls from t through t+MUL_CYC and enters E at t+MUL_CYC+1.
- Reset asserted mid-stall: the slots clear immediately and stall drops within the same cycle.

## Structure
- Shared header `head.v` holds:
  - fwd select codes (FWD_NONE/E/M/W)
  - md op codes
  - tmux_size reused as the forward width (2)
- One sub-module, md_busy_counter (parameters MUL_CYC, DIV_CYC; inputs clk, reset, md_op; output busy).
- Slot registers and compare logic stay in hazard_scoreboard.

## Test plan
- addu $3 (tnew 0) in E, beq reading $3 (tuse 0) in D -> stall=0, fwd_d_rs=1.
- lw $5 (tnew 2) then addu reading $5 in rs (tuse 1) -> stall=1 for 1 cycle, then E-stage fwd_e_rs=3 (from W) once lw reaches W.
- Write to $0 in E with d_rs=0 -> stall=0, all fwd=0.
- $7 written in E (tnew 1) and in M (tnew 0), D reads $7 (tuse 0) -> stall=1 and fwd_d_rs=0, never 2.
- div at cycle t, then mflo in D -> md_busy high t+1…t+10, stall held t…t+10, e_md_op=10 only at t.
- reset pulse while a div is busy at count 6 -> md_busy=0 and stall=0 immediately; the counter does not resume after reset releases.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared codes for the hazard scoreboard: forward selects, md op classes,
// and a helper that picks the forward source from the nearest producer.
package hazard_scoreboard_pkg;

  // Forward select width (same width as the operand mux select)
  localparam int TMUX_SIZE = 2;

  localparam logic [TMUX_SIZE-1:0] FWD_NONE = 2'd0;
  localparam logic [TMUX_SIZE-1:0] FWD_E    = 2'd1;
  localparam logic [TMUX_SIZE-1:0] FWD_M    = 2'd2;
  localparam logic [TMUX_SIZE-1:0] FWD_W    = 2'd3;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  // hit[0]=E, hit[1]=M, hit[2]=W. Only the nearest hit is considered; if that
  // producer's result is not ready yet, no forwarding happens at all, so an
  // older (stale) copy of the register is never selected.
  function automatic logic [TMUX_SIZE-1:0] fwd_pick(input logic [2:0] hit,
                                                    input logic [2:0] ready);
    logic [TMUX_SIZE-1:0] sel;
    sel = FWD_NONE;
    if (hit[0])      sel = ready[0] ? FWD_E : FWD_NONE;
    else if (hit[1]) sel = ready[1] ? FWD_M : FWD_NONE;
    else if (hit[2]) sel = ready[2] ? FWD_W : FWD_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide busy countdown: loaded when a md op sits in E, then counts
// down to zero; busy while nonzero.
module md_busy_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_op,
  output logic       busy
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: a new md start reloads, otherwise decrement towards zero
  always_comb begin
    cnt_d = cnt_q;
    if (md_op == MD_MUL)      cnt_d = CW'(MUL_CYC);
    else if (md_op == MD_DIV) cnt_d = CW'(DIV_CYC);
    else if (cnt_q != '0)     cnt_d = cnt_q - CW'(1);
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks destination/readiness of E, M and W, and
// derives the D-stage stall and every forward select from that record.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        d_rs,
  input  logic [AW-1:0]        d_rt,
  input  logic                 d_use_rs,
  input  logic                 d_use_rt,
  input  logic [TW-1:0]        d_tuse_rs,
  input  logic [TW-1:0]        d_tuse_rt,
  input  logic [AW-1:0]        d_wa,
  input  logic                 d_we,
  input  logic [TW-1:0]        d_tnew,
  input  logic [1:0]           d_md_op,
  input  logic                 d_md_use,
  output logic                 stall,
  output logic [TMUX_SIZE-1:0] fwd_d_rs,
  output logic [TMUX_SIZE-1:0] fwd_d_rt,
  output logic [TMUX_SIZE-1:0] fwd_e_rs,
  output logic [TMUX_SIZE-1:0] fwd_e_rt,
  output logic [TMUX_SIZE-1:0] fwd_m_rt,
  output logic [1:0]           e_md_op,
  output logic                 md_busy
);

  typedef struct packed {
    logic [AW-1:0] wa;
    logic          we;
    logic [TW-1:0] tnew;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          use_rs;
    logic          use_rt;
    logic [1:0]    md_op;
  } e_slot_t;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic          we;
    logic [TW-1:0] tnew;
    logic [AW-1:0] rt;
    logic          use_rt;
  } m_slot_t;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic          we;
  } w_slot_t;

  e_slot_t e_q, e_d;
  m_slot_t m_q, m_d;
  w_slot_t w_q, w_d;

  // A write to $0 is never a real producer
  logic e_wr, m_wr, w_wr;
  logic e_ready, m_ready;
  assign e_wr    = e_q.we && (e_q.wa != '0);
  assign m_wr    = m_q.we && (m_q.wa != '0);
  assign w_wr    = w_q.we && (w_q.wa != '0);
  assign e_ready = (e_q.tnew == '0);
  assign m_ready = (m_q.tnew == '0);

  // D-stage sources: index 0 is rs, index 1 is rt
  logic [1:0][AW-1:0]        d_src;
  logic [1:0]                d_use;
  logic [1:0][TW-1:0]        d_tuse;
  logic [1:0][TMUX_SIZE-1:0] d_fwd;
  logic [1:0]                d_stall_src;

  assign d_src  = {d_rt, d_rs};
  assign d_use  = {d_use_rt, d_use_rs};
  assign d_tuse = {d_tuse_rt, d_tuse_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_d_src
      logic hit_e, hit_m, hit_w;
      assign hit_e = d_use[gi] && e_wr && (e_q.wa == d_src[gi]);
      assign hit_m = d_use[gi] && m_wr && (m_q.wa == d_src[gi]);
      assign hit_w = d_use[gi] && w_wr && (w_q.wa == d_src[gi]);
      assign d_fwd[gi] = fwd_pick({hit_w, hit_m, hit_e}, {1'b1, m_ready, e_ready});
      assign d_stall_src[gi] = (hit_e && (e_q.tnew > d_tuse[gi])) ||
                               (hit_m && (m_q.tnew > d_tuse[gi]));
    end
  endgenerate

  // E-stage sources look only at the older M and W stages
  logic [1:0][AW-1:0]        e_src;
  logic [1:0]                e_use;
  logic [1:0][TMUX_SIZE-1:0] e_fwd;

  assign e_src = {e_q.rt, e_q.rs};
  assign e_use = {e_q.use_rt, e_q.use_rs};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_e_src
      logic hit_m, hit_w;
      assign hit_m = e_use[gi] && m_wr && (m_q.wa == e_src[gi]);
      assign hit_w = e_use[gi] && w_wr && (w_q.wa == e_src[gi]);
      assign e_fwd[gi] = fwd_pick({hit_w, hit_m, 1'b0}, {1'b1, m_ready, 1'b0});
    end
  endgenerate

  // M-stage rt (store data) can only come from W
  logic m_rt_hit_w;
  assign m_rt_hit_w = m_q.use_rt && w_wr && (w_q.wa == m_q.rt);

  logic md_stall;
  assign md_stall = d_md_use && ((e_q.md_op != MD_NONE) || md_busy);

  assign stall    = (|d_stall_src) || md_stall;
  assign fwd_d_rs = d_fwd[0];
  assign fwd_d_rt = d_fwd[1];
  assign fwd_e_rs = e_fwd[0];
  assign fwd_e_rt = e_fwd[1];
  assign fwd_m_rt = fwd_pick({m_rt_hit_w, 2'b00}, 3'b100);
  assign e_md_op  = e_q.md_op;

  // Next slot contents: shift E->M->W, insert a bubble into E on stall
  always_comb begin
    m_d.wa     = e_q.wa;
    m_d.we     = e_q.we;
    m_d.tnew   = e_ready ? '0 : (e_q.tnew - TW'(1));
    m_d.rt     = e_q.rt;
    m_d.use_rt = e_q.use_rt;

    w_d.wa = m_q.wa;
    w_d.we = m_q.we;

    e_d = '0;
    if (!stall) begin
      e_d.wa     = d_wa;
      e_d.we     = d_we;
      e_d.tnew   = d_tnew;
      e_d.rs     = d_rs;
      e_d.rt     = d_rt;
      e_d.use_rs = d_use_rs;
      e_d.use_rt = d_use_rt;
      e_d.md_op  = d_md_op;
    end
  end

  // Slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_counter #(
    .MUL_CYC(MUL_CYC),
    .DIV_CYC(DIV_CYC)
  ) u_md_busy (
    .clk  (clk),
    .reset(reset),
    .md_op(e_q.md_op),
    .busy (md_busy)
  );

endmodule
